// File: rtl/dsp_chain_sop2_int16_array_if.sv
// Handshake bundle for dsp_chain_sop2_int16_array.
//   in_valid/in_ready/in_data/in_acc : operand beat toward the block
//   out_valid/out_ready/out_data/out_overflow : result beat from the block
// master = operand source / result sink, slave = the DSP block.
interface dsp_chain_sop2_int16_array_if #(
   parameter int unsigned LANES = 8,
   parameter int unsigned CHAIN = 4,
   parameter int unsigned ACC_W = 32
);
   logic                        in_valid;
   logic                        in_ready;
   logic [LANES*CHAIN*64-1:0]   in_data;
   logic                        in_acc;
   logic                        out_valid;
   logic                        out_ready;
   logic [LANES*ACC_W-1:0]      out_data;
   logic [LANES-1:0]            out_overflow;

   modport master (
      output in_valid, in_data, in_acc, out_ready,
      input  in_ready, out_valid, out_data, out_overflow
   );

   modport slave (
      input  in_valid, in_data, in_acc, out_ready,
      output in_ready, out_valid, out_data, out_overflow
   );
endinterface

// File: rtl/dsp_chain_sop2_int16_array.sv
// LANES independent lanes, each summing CHAIN signed int16 a0*b0+a1*b1 terms,
// with optional accumulation across beats and saturate/wrap output formatting.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of dsp_chain_sop2_int16_array_if (valid/ready in and out)
// Pipeline: P1 operands -> P2 products -> P3 lane sums -> P4 accumulate/format.
// All four stages share one enable, so a stalled output freezes the whole chain.
module dsp_chain_sop2_int16_array #(
   parameter int unsigned LANES    = 8,
   parameter int unsigned CHAIN    = 4,
   parameter int unsigned ACC_W    = 32,
   parameter bit          SATURATE = 1'b0
) (
   input logic                          clk,
   input logic                          reset,
   dsp_chain_sop2_int16_array_if.slave  bus
);

   localparam int unsigned DW  = LANES * CHAIN * 64;
   localparam int unsigned NT  = LANES * CHAIN;
   localparam int unsigned PPL = CHAIN * 2;
   localparam int unsigned NP  = LANES * PPL;
   // Full-precision lane sum: 2*CHAIN products of 32 bits never overflow this.
   localparam int unsigned SW  = 32 + $clog2(2 * CHAIN);
   // Accumulator + sum needs one bit beyond the wider of the two.
   localparam int unsigned TW  = ((ACC_W > SW) ? ACC_W : SW) + 1;

   localparam logic signed [TW-1:0] MAX_T = {{(TW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [TW-1:0] MIN_T = {{(TW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

   // Global pipeline enable: advance unless a result is waiting on the sink.
   logic en_c;

   logic                     p1_valid_q, p1_acc_q;
   logic [DW-1:0]            p1_data_q;

   logic                     p2_valid_q, p2_acc_q;
   logic signed [31:0]       prod_d [NP];
   logic signed [31:0]       prod_q [NP];

   logic                     p3_valid_q, p3_acc_q;
   logic signed [SW-1:0]     sum_d [LANES];
   logic signed [SW-1:0]     sum_q [LANES];

   logic signed [TW-1:0]     t_c   [LANES];
   logic signed [ACC_W-1:0]  res_d [LANES];
   logic [LANES-1:0]         ovf_d;

   // Lane accumulators double as the output data registers: both equal R.
   logic signed [ACC_W-1:0]  acc_q [LANES];
   logic [LANES-1:0]         ovf_q;
   logic                     out_valid_q;
   logic [LANES*ACC_W-1:0]   out_data_c;

   assign en_c              = !out_valid_q || bus.out_ready;
   assign bus.in_ready      = en_c;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_overflow  = ovf_q;
   assign bus.out_data      = out_data_c;

   // Pack lane results onto the output bus.
   always_comb begin
      out_data_c = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         out_data_c[l*ACC_W +: ACC_W] = acc_q[l];
      end
   end

   // P1: operand capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p1_valid_q <= 1'b0;
         p1_acc_q   <= 1'b0;
         p1_data_q  <= '0;
      end else if (en_c) begin
         p1_valid_q <= bus.in_valid;
         p1_acc_q   <= bus.in_acc;
         p1_data_q  <= bus.in_data;
      end
   end

   // Signed 16x16 products; operands are sign-extended before multiplying.
   always_comb begin
      for (int unsigned i = 0; i < NT; i++) begin
         prod_d[2*i]   = 32'($signed(p1_data_q[i*64      +: 16]))
                       * 32'($signed(p1_data_q[i*64 + 16 +: 16]));
         prod_d[2*i+1] = 32'($signed(p1_data_q[i*64 + 32 +: 16]))
                       * 32'($signed(p1_data_q[i*64 + 48 +: 16]));
      end
   end

   // P2: product registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p2_valid_q <= 1'b0;
         p2_acc_q   <= 1'b0;
         for (int unsigned i = 0; i < NP; i++) begin
            prod_q[i] <= '0;
         end
      end else if (en_c) begin
         p2_valid_q <= p1_valid_q;
         p2_acc_q   <= p1_acc_q;
         for (int unsigned i = 0; i < NP; i++) begin
            prod_q[i] <= prod_d[i];
         end
      end
   end

   // Per-lane reduction of all 2*CHAIN products at full precision.
   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         sum_d[l] = '0;
         for (int unsigned j = 0; j < PPL; j++) begin
            sum_d[l] = sum_d[l] + SW'(prod_q[l*PPL + j]);
         end
      end
   end

   // P3: lane sum registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p3_valid_q <= 1'b0;
         p3_acc_q   <= 1'b0;
         for (int unsigned l = 0; l < LANES; l++) begin
            sum_q[l] <= '0;
         end
      end else if (en_c) begin
         p3_valid_q <= p2_valid_q;
         p3_acc_q   <= p2_acc_q;
         for (int unsigned l = 0; l < LANES; l++) begin
            sum_q[l] <= sum_d[l];
         end
      end
   end

   // Accumulate at wide width, then clamp or wrap to ACC_W; flag any change.
   always_comb begin
      ovf_d = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         t_c[l] = (p3_acc_q ? TW'(acc_q[l]) : TW'(0)) + TW'(sum_q[l]);
         if (SATURATE) begin
            if (t_c[l] > MAX_T) begin
               res_d[l] = ACC_W'(MAX_T);
            end else if (t_c[l] < MIN_T) begin
               res_d[l] = ACC_W'(MIN_T);
            end else begin
               res_d[l] = t_c[l][ACC_W-1:0];
            end
         end else begin
            res_d[l] = t_c[l][ACC_W-1:0];
         end
         ovf_d[l] = (TW'(res_d[l]) != t_c[l]);
      end
   end

   // P4: output/accumulator registers; bubbles only clear out_valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         ovf_q       <= '0;
         for (int unsigned l = 0; l < LANES; l++) begin
            acc_q[l] <= '0;
         end
      end else if (en_c) begin
         out_valid_q <= p3_valid_q;
         if (p3_valid_q) begin
            ovf_q <= ovf_d;
            for (int unsigned l = 0; l < LANES; l++) begin
               acc_q[l] <= res_d[l];
            end
         end
      end
   end

endmodule

// File: doc/dsp_chain_sop2_int16_array.md
Name: dsp_chain_sop2_int16_array

Overview:
Parametrised successor to the fixed 8-lane, 4-deep sum-of-two-products DSP chain array. It provides LANES independent lanes, each reducing CHAIN stages of signed int16 a0*b0+a1*b1 products. Each lane adds a streaming valid/ready handshake, a fixed pipeline, optional per-lane accumulation across beats, and a selectable saturate or wrap output. It sits between an operand-staging buffer and a result FIFO in the proxy-benchmark datapath.

Parameters:
LANES, 8, number of independent lanes
CHAIN, 4, sop2 stages per lane (>=1)
ACC_W, 32, output/accumulator width per lane (>=32)
SATURATE, 0, 1 = clamp to signed ACC_W range; 0 = two's-complement wrap

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low; clears all state
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts the beat this cycle
in_data  input  LANES*CHAIN*64  operands, layout below
in_acc  input  1  1 = add the beat onto the lane accumulators; 0 = start new sums
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
out_data  output  LANES*ACC_W  lane l result at [l*ACC_W +: ACC_W]
out_overflow  output  LANES  per-lane saturation/wrap flag for the current result

Behaviour:
- Operand layout: lane l, stage k occupies in_data[(l*CHAIN+k)*64 +: 64]. Fields: a0=[15:0], b0=[31:16], a1=[47:32], b1=[63:48]. All fields are signed two's complement.
- Lane sum S = sum over k of (a0*b0 + a1*b1).
  - Each product is full 32-bit signed.
  - S is held at full precision (32+clog2(2*CHAIN) bits); it never overflows internally.
- Pipeline has 4 register stages with one global enable, en = !out_valid || out_ready. in_ready = en.
  - P1: capture operands, in_valid, in_acc when en.
  - P2: products.
  - P3: reduction to S.
  - P4: accumulate/format into out_data, out_valid, out_overflow.
- Valid bits travel with their data. A beat is accepted when in_valid && in_ready. Its result appears 4 cycles later if en stays high.
- Throughput is one beat per cycle while out_ready=1.
- When en=0, all stages hold. out_data, out_valid and out_overflow stay stable until out_ready (AXI-style: no change while out_valid && !out_ready).
- Bubbles (invalid stages) advance with en but do not update accumulators or outputs' data; out_valid drops to 0 when a bubble reaches P4.
- Accumulate at P4, for a valid beat only:
  - T = (acc_flag ? ACC[l] : 0) + S, computed at wide width.
  - R = SATURATE ? clamp(T, -2^(ACC_W-1), 2^(ACC_W-1)-1) : T[ACC_W-1:0].
  - out_overflow[l] = (R != T).
  - out_data lane = R; ACC[l] = R.
- ACC[l] is internal, one per lane, and reset to 0. After saturation or wrap, the accumulator continues from R.
- in_acc=1 on the first beat after reset accumulates onto 0.
- Reset (asynchronous assert, any time): all stage valids=0, ACC=0, out_data=0, out_overflow=0, out_valid=0. In-flight beats are discarded. in_ready=1 while reset is deasserted and the pipeline is empty.
- Simultaneous input accept and output consume in the same cycle is legal and is the steady state.

Test Plan:
- Single beat, LANES=8, CHAIN=4: all a0=b0=a1=b1=1, in_acc=0, out_ready=1 -> out_valid exactly 4 cycles after accept; each lane = 8; overflow=0.
- Signed mix: lane 0 stage 0 a0=-3, b0=7, a1=-32768, b1=-32768, other stages 0 -> lane 0 = -21+1073741824 = 1073741803.
- Accumulate: beats with sums 10, 20, 30, with in_acc=0,1,1 -> outputs 10, 30, 60. A 4th beat with in_acc=0 and sum 5 -> 5.
- Overflow: ACC_W=32, every field -32768, 3 beats with in_acc=0,1,1 (each S=2^33):
  - SATURATE=1 -> 2147483647 on all beats, overflow=1.
  - SATURATE=0 -> 0 on all beats, overflow=1.
- Backpressure: stream 10 beats, out_ready toggling every 2 cycles -> no loss or duplication, order preserved, out_data stable while stalled, in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-stream with 3 beats in flight and ACC nonzero -> out_valid=0 and out_data=0 immediately. The next beat with in_acc=1 and sum 7 -> 7.
